wb_mem_responder: RTL and testbench
===================================

Name: wb_mem_responder

Overview:
Main-memory responder sitting below cache L2 in the memory hierarchy. It answers L2 fill reads after a fixed latency and absorbs L2 write-backs into a small coalescing write-back buffer. The buffer drains to the storage array in the background. Reads forward the newest buffered data, so a fill never returns stale data.

Parameters:
DATA_W, 11, word width (matches the L2 line data width)
ADDR_W, 3, address width; array holds 2^ADDR_W words (ADDR_W <= 4)
RD_LAT, 3, cycles from read acceptance to resp_valid (>= 1)
WR_LAT, 2, cycles to retire one buffered write into the array (>= 1)
WB_DEPTH, 2, write-back buffer entries (>= 1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  L2 presents a request
req_write  input  1  1 = write-back, 0 = fill read
req_addr  input  ADDR_W  request address
req_data  input  DATA_W  write-back data (ignored on reads)
req_ready  output  1  responder accepts a request this cycle
resp_valid  output  1  read data valid
resp_ready  input  1  L2 consumes the response
resp_data  output  DATA_W  read data
resp_addr  output  ADDR_W  address of the returned read
busy  output  1  FSM not idle or buffer not empty

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM goes to IDLE; buffer is emptied and pending writes are discarded.
  - All array words are cleared to 0; drain timer is cleared.
  - Outputs after reset: req_ready=1, resp_valid=0, resp_data=0, resp_addr=0, busy=0.
  - rst has priority over every other event, including mid-read or mid-drain.
- Handshake and acceptance:
  - A request is accepted when req_valid && req_ready.
  - req_ready = (state==IDLE) && (wb_count < WB_DEPTH). It does not depend on req_valid.
- FSM states: IDLE, READ_WAIT, RESP.
  - IDLE + accepted read -> READ_WAIT, latency counter loaded with RD_LAT-1.
  - IDLE + accepted write -> stay in IDLE.
  - READ_WAIT: counter decrements each cycle; at 0 go to RESP.
  - RESP: resp_valid=1 and is held, with resp_data/resp_addr stable, until resp_ready=1; then IDLE. resp_valid falls in the cycle after the handshake.
- Read timing and data:
  - Read accepted at edge T gives resp_valid=1 from cycle T+RD_LAT.
  - Data is captured at acceptance: newest buffer entry matching req_addr if any, else array[req_addr].
  - A read never blocks on or waits for draining.
- Write-back buffer:
  - FIFO of {addr,data} entries.
  - Accepted write whose address matches a buffered entry that is not being popped this cycle: overwrite that entry's data; count unchanged (coalesce).
  - Otherwise the write is appended at the tail.
- Drain:
  - While the buffer is non-empty, the drain timer counts WR_LAT cycles.
  - On expiry the head is written to the array and popped, and the timer restarts for the next entry.
  - Drain runs in every FSM state.
- Simultaneous events:
  - A pop and an append in the same cycle leave the count unchanged.
  - A write matching the head being popped is appended, not coalesced.
  - A read accepted in the cycle the matching head is popped forwards the buffer data (the entry is still present at capture).
- Full buffer: req_ready=0 until the next pop; reads also stall then.
- busy = (state != IDLE) || (wb_count != 0).

Test Plan:
- Parameters DATA_W=11, ADDR_W=3, RD_LAT=3, WR_LAT=2, WB_DEPTH=2 for all scenarios.
- Reset, then read addr 101 accepted at T -> resp_valid=1 at T+3 with resp_data=0, resp_addr=101; resp_ready=1 -> resp_valid=0 next cycle.
- Write 001/01110110101, then read 001 in the next cycle -> resp_data=01110110101 (forwarded). After 2 further cycles busy=0 and a re-read of 001 returns the same value from the array.
- Writes to 001 then 110 on consecutive cycles -> wb_count=2, req_ready=0 until the first drain pop (2 cycles after the first write); array[001] is updated before array[110].
- Write 111/10001010010, then 111/01110110000 before it drains -> count stays 1; a final read of 111 returns 01110110000.
- Read accepted with resp_ready held low 4 cycles after resp_valid -> resp_valid, resp_data and resp_addr stay stable and req_ready=0 throughout; the buffer keeps draining.
- Assert rst during READ_WAIT with 1 buffered write to 010 -> next cycle resp_valid=0, req_ready=1, busy=0; a subsequent read of 010 returns 0.

Source files
------------

// File: rtl/wb_mem_responder_if.sv
// rtl/wb_mem_responder_if.sv - L2-facing request/response bus of the main-memory responder
interface wb_mem_responder_if #(
    parameter int DATA_W = 11,
    parameter int ADDR_W = 3
);
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [ADDR_W-1:0] resp_addr;
    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_addr, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_addr, busy
    );
endinterface

// File: rtl/wb_mem_responder.sv
// rtl/wb_mem_responder.sv - fixed-latency fill responder with coalescing write-back buffer
module wb_mem_responder #(
    parameter int DATA_W   = 11,
    parameter int ADDR_W   = 3,
    parameter int RD_LAT   = 3,
    parameter int WR_LAT   = 2,
    parameter int WB_DEPTH = 2
) (
    input logic              clk,
    input logic              rst,
    wb_mem_responder_if.slave bus
);
    localparam int MEM_N = 1 << ADDR_W;
    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam int TMR_W = $clog2(WR_LAT + 1);
    localparam int CNT_W = $clog2(WB_DEPTH + 1);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WR_LAT - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(WB_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, READ_WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;

    logic [DATA_W-1:0] mem_q [MEM_N];
    logic [DATA_W-1:0] mem_d [MEM_N];
    logic [ADDR_W-1:0] wb_addr_q [WB_DEPTH];
    logic [ADDR_W-1:0] wb_addr_d [WB_DEPTH];
    logic [DATA_W-1:0] wb_data_q [WB_DEPTH];
    logic [DATA_W-1:0] wb_data_d [WB_DEPTH];
    logic [CNT_W-1:0]  wb_count_q, wb_count_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;

    logic              req_ready;
    logic              acc_rd, acc_wr, pop;
    logic [DATA_W-1:0] fwd_data;
    logic              co_hit;
    logic [CNT_W-1:0]  co_idx;

    assign req_ready      = (state_q == IDLE) && (wb_count_q < DEPTH_C);
    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_addr  = resp_addr_q;
    assign bus.busy       = (state_q != IDLE) || (wb_count_q != '0);

    // Buffer lookup: newest match forwards to reads; a head that is
    // leaving this cycle cannot absorb a coalescing write.
    always_comb begin
        pop      = (wb_count_q != '0) && (tmr_q == TMR_LAST);
        acc_rd   = bus.req_valid && req_ready && !bus.req_write;
        acc_wr   = bus.req_valid && req_ready && bus.req_write;
        fwd_data = mem_q[bus.req_addr];
        co_hit   = 1'b0;
        co_idx   = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if ((CNT_W'(i) < wb_count_q) && (wb_addr_q[i] == bus.req_addr)) begin
                fwd_data = wb_data_q[i];
                if (!(pop && (i == 0))) begin
                    co_hit = 1'b1;
                    co_idx = CNT_W'(i);
                end
            end
        end
    end

    always_comb begin
        mem_d      = mem_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        wb_count_d = wb_count_q;
        tmr_d      = tmr_q;
        if (pop) begin
            mem_d[wb_addr_q[0]] = wb_data_q[0];
            for (int i = 0; i < WB_DEPTH - 1; i++) begin
                wb_addr_d[i] = wb_addr_q[i+1];
                wb_data_d[i] = wb_data_q[i+1];
            end
            wb_count_d = wb_count_q - ONE_C;
            tmr_d      = '0;
        end else if (wb_count_q != '0) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
        // Indices below refer to the already-shifted queue.
        if (acc_wr) begin
            if (co_hit) begin
                wb_data_d[pop ? (co_idx - ONE_C) : co_idx] = bus.req_data;
            end else begin
                wb_addr_d[wb_count_d] = bus.req_addr;
                wb_data_d[wb_count_d] = bus.req_data;
                wb_count_d            = wb_count_d + ONE_C;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_addr_d  = resp_addr_q;
        case (state_q)
            IDLE: begin
                if (acc_rd) begin
                    state_d     = READ_WAIT;
                    lat_d       = LAT_INIT;
                    resp_data_d = fwd_data;
                    resp_addr_d = bus.req_addr;
                end
            end
            READ_WAIT: begin
                if (lat_q == '0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_addr_q  <= '0;
            wb_count_q   <= '0;
            tmr_q        <= '0;
            for (int i = 0; i < MEM_N; i++) begin
                mem_q[i] <= '0;
            end
            for (int i = 0; i < WB_DEPTH; i++) begin
                wb_addr_q[i] <= '0;
                wb_data_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_addr_q  <= resp_addr_d;
            wb_count_q   <= wb_count_d;
            tmr_q        <= tmr_d;
            mem_q        <= mem_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
        end
    end
endmodule

// File: tb/tb_wb_mem_responder.sv
// tb/tb_wb_mem_responder.sv - randomized bench for wb_mem_responder with a queue-based reference model
module tb_wb_mem_responder;
    localparam int DATA_W   = 11;
    localparam int ADDR_W   = 3;
    localparam int RD_LAT   = 3;
    localparam int WR_LAT   = 2;
    localparam int WB_DEPTH = 2;

    logic clk;
    logic rst;

    wb_mem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    wb_mem_responder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT),
        .WR_LAT(WR_LAT), .WB_DEPTH(WB_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory image, FIFO of pending write-backs, absolute
    // cycle at which the head drains, and the outstanding read.
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              wbq[$];
    logic [DATA_W-1:0] m_mem [1 << ADDR_W];
    int                cyc      = 0;
    int                next_pop = 0;
    int                due      = 0;
    bit                m_busy_rd = 0;
    bit                m_live   = 0;
    logic [DATA_W-1:0] m_rdata;
    logic [ADDR_W-1:0] m_raddr;
    bit                m_rdy, m_acc, m_pop;
    int                m_hit;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_live = 1;
            wbq.delete();
            foreach (m_mem[i]) m_mem[i] = '0;
            m_busy_rd = 0;
        end else begin
            m_rdy = !m_busy_rd && (wbq.size() < WB_DEPTH);
            m_acc = bus.req_valid && m_rdy;
            if (m_busy_rd && cyc > due && bus.resp_ready) m_busy_rd = 0;
            m_pop = (wbq.size() > 0) && (cyc == next_pop);
            if (m_acc && !bus.req_write) begin
                m_rdata = m_mem[bus.req_addr];
                foreach (wbq[i]) if (wbq[i].a == bus.req_addr) m_rdata = wbq[i].d;
                m_raddr   = bus.req_addr;
                m_busy_rd = 1;
                due       = cyc + RD_LAT;
            end
            if (m_pop) begin
                m_mem[wbq[0].a] = wbq[0].d;
                void'(wbq.pop_front());
                if (wbq.size() > 0) next_pop = cyc + WR_LAT;
            end
            if (m_acc && bus.req_write) begin
                m_hit = -1;
                foreach (wbq[i]) if (wbq[i].a == bus.req_addr) m_hit = i;
                if (m_hit >= 0) begin
                    wbq[m_hit].d = bus.req_data;
                end else begin
                    if (wbq.size() == 0) next_pop = cyc + WR_LAT;
                    wbq.push_back({bus.req_addr, bus.req_data});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("req_ready", 32'(bus.req_ready), 32'(!m_busy_rd && (wbq.size() < WB_DEPTH)));
            chk("resp_valid", 32'(bus.resp_valid), 32'(m_busy_rd && cyc >= due));
            chk("busy", 32'(bus.busy), 32'(m_busy_rd || (wbq.size() != 0)));
            if (m_busy_rd && cyc >= due) begin
                chk("resp_data", 32'(bus.resp_data), 32'(m_rdata));
                chk("resp_addr", 32'(bus.resp_addr), 32'(m_raddr));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_req(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit done = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_data  = d;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            done = bus.req_ready;
            @(posedge clk);
            #2;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL req_accept_timeout: got not-accepted expected accepted");
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic rd_check(input string nm, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] exp, input int hold);
        bit got = 0;
        int k = 0;
        if (hold > 0) bus.resp_ready = 1'b0;
        do_req(1'b0, a, '0);
        while (!got && k < 40) begin
            @(negedge clk);
            if (bus.resp_valid) got = 1;
            else begin
                @(posedge clk);
                k++;
            end
        end
        chk({nm, "_seen"}, 32'(got), 32'd1);
        chk({nm, "_lat"}, 32'(k), 32'(RD_LAT));
        chk({nm, "_data"}, 32'(bus.resp_data), 32'(exp));
        chk({nm, "_addr"}, 32'(bus.resp_addr), 32'(a));
        for (int j = 0; j < hold; j++) begin
            @(posedge clk);
            @(negedge clk);
            chk({nm, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
            chk({nm, "_hold_data"}, 32'(bus.resp_data), 32'(exp));
            chk({nm, "_hold_addr"}, 32'(bus.resp_addr), 32'(a));
            chk({nm, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
        end
        if (hold > 0) begin
            @(posedge clk);
            #2;
            bus.resp_ready = 1'b1;
        end
        @(posedge clk);
        #2;
        @(negedge clk);
        chk({nm, "_fall"}, 32'(bus.resp_valid), 32'd0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.resp_ready = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", 32'(bus.resp_data), 32'd0);
        chk("rst_resp_addr", 32'(bus.resp_addr), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #2;

        rd_check("rd_reset", 3'b101, 11'd0, 0);

        do_req(1'b1, 3'b001, 11'b01110110101);
        rd_check("rd_fwd", 3'b001, 11'b01110110101, 0);
        @(negedge clk);
        chk("fwd_busy_idle", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #2;
        rd_check("rd_array", 3'b001, 11'b01110110101, 0);

        do_req(1'b1, 3'b001, 11'h2A5);
        do_req(1'b1, 3'b110, 11'h15A);
        @(negedge clk);
        chk("full_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("after_pop_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #2;
        idle(4);
        rd_check("rd_001", 3'b001, 11'h2A5, 0);
        rd_check("rd_110", 3'b110, 11'h15A, 0);

        do_req(1'b1, 3'b111, 11'b10001010010);
        do_req(1'b1, 3'b111, 11'b01110110000);
        @(negedge clk);
        chk("coalesce_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #2;
        idle(4);
        rd_check("rd_coal", 3'b111, 11'b01110110000, 0);

        do_req(1'b1, 3'b100, 11'h555);
        idle(4);
        do_req(1'b1, 3'b011, 11'h123);
        rd_check("rd_hold", 3'b100, 11'h555, 4);
        @(negedge clk);
        chk("hold_drained", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #2;
        rd_check("rd_011", 3'b011, 11'h123, 0);

        do_req(1'b1, 3'b010, 11'h3C3);
        do_req(1'b0, 3'b011, '0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #2;
        rd_check("rd_after_rst", 3'b010, 11'd0, 0);

        for (int c = 0; c < 600; c++) begin
            rst            = ($urandom_range(0, 149) == 0);
            bus.req_valid  = ($urandom_range(0, 2) != 0);
            bus.req_write  = ($urandom_range(0, 1) == 1);
            bus.req_addr   = ADDR_W'($urandom_range(0, 3));
            bus.req_data   = DATA_W'($urandom);
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            idle(1);
        end
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
